hazard_md: RTL and testbench
============================

Name: hazard_md

Overview:
- Parametrised hazard controller for the 5-stage pipeline (F/D/E/M/W).
- Same Tuse/Tnew stall and D/E/M forwarding decisions as the current controller, with generic Tuse/Tnew widths and an added E→D forward path.
- Adds a sequential multiply/divide busy tracker. It stalls HI/LO-class instructions in D while the MDU is running.
- Sits between the decode control and the pipeline registers. Drives PC/FD freeze, DE flush and all forward-mux selects.

Parameters:
REG_AW, 5, register-address width
T_W, 2, width of Tuse/Tnew fields
MULT_CYCLES, 5, MDU busy cycles after a mult/multu start
DIV_CYCLES, 10, MDU busy cycles after a div/divu start
CNT_W, 4, MDU counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
tUseRs  in  T_W  Tuse of rs for the D instruction; all-ones = not used
tUseRt  in  T_W  Tuse of rt for the D instruction; all-ones = not used
tNew_E  in  T_W  remaining Tnew of the E instruction
tNew_M  in  T_W  remaining Tnew of the M instruction
rs_D, rt_D, rs_E, rt_E, rt_M  in  REG_AW  source register numbers
rIR_E, rIR_M, rIR_W  in  REG_AW  destination register per stage
regWrite_E, regWrite_M, regWrite_W  in  1  destination valid
md_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
mdStart_E  in  1  E instruction starts an MDU operation this cycle
mdDiv_E  in  1  with mdStart_E: 1 = div type, 0 = mult type
stall  out  1  freeze PC and F/D register
flush_E  out  1  load a bubble into D/E (= stall)
F_mux1_D, F_mux2_D  out  2  D forward select: 3 = E, 2 = M, 1 = W, 0 = RF
F_mux1_E, F_mux2_E  out  2  E forward select: 2 = M, 1 = W, 0 = none
F_mux1_M  out  1  M store-data forward: 1 = W
mdBusy  out  1  MDU counter non-zero

Behaviour:
- Reset (async, active-high): MDU counter = 0. All outputs follow from that, so mdBusy = 0 and stall = 0 once combinational inputs are idle.
- Register-hazard stall, evaluated for rs and rt independently:
  - Stall when the source is non-zero, its Tuse is not all-ones, and it matches a writing producer.
  - For an E producer (rIR_E, regWrite_E): stall when Tuse < tNew_E.
  - For an M producer (rIR_M, regWrite_M): stall when Tuse < tNew_M.
  - All comparisons are unsigned, T_W bits wide.
  - Source register 0 never stalls and never forwards.
- MDU counter (sequential, posedge clk):
  - mdStart_E = 1 loads DIV_CYCLES if mdDiv_E, else MULT_CYCLES. This applies even if the counter is non-zero, in which case it reloads.
  - Otherwise, if the counter ≠ 0, decrement by 1. Saturate at 0; never wrap.
  - mdBusy = (cnt ≠ 0).
- MDU stall: md_D & (mdBusy | mdStart_E).
  - The start cycle itself stalls, so a second md instruction never enters E while the MDU is running.
  - For the md instruction following a mult start, the stall lasts MULT_CYCLES + 1 cycles.
- stall = register stall | MDU stall. flush_E = stall.
- D forwarding priority, highest first:
  - E: source = rIR_E, regWrite_E, tNew_E = 0 → 3.
  - M → 2.
  - W → 1.
  - Otherwise 0.
- E and M forwarding: M before W, as encoded above. F_mux1_M compares rt_M with the W producer.
- Simultaneous reset and mdStart_E: reset wins and the counter stays 0.
- Reset asserted mid-operation: the counter clears immediately, without waiting for a clock edge.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- When defined:
  - Adds output stallCnt, 32 bits: counts cycles with stall = 1. Saturates at 0xFFFFFFFF. Async cleared by reset.
  - Adds output mdStallCnt, 32 bits: counts cycles where the MDU stall term alone is 1. Same saturation and reset rules.
- When undefined: neither port nor either register exists. All other behaviour is identical.

Test Plan:
- lw $2 in E (tNew_E = 2, rIR_E = 2); D add using rs = 2 with tUseRs = 1 → stall = 1, flush_E = 1. The next cycle, with the lw in M (tNew_M = 1), stall = 0 and F_mux1_E = 2 on the following cycle.
- lui $3 in E (tNew_E = 0); D beq with rs = 3, tUseRs = 0 → stall = 0, F_mux1_D = 3. Same register also in M and W → still 3.
- mult in E (mdStart_E = 1, mdDiv_E = 0) with mflo in D → stall high for exactly 6 cycles; mdBusy high for 5 cycles. Release on the cycle the counter reads 0.
- div start followed by non-md instructions → stall = 0 throughout; mdBusy high for 10 cycles. An mfhi arriving when cnt = 3 → exactly 3 stall cycles.
- Reset pulsed while cnt = 7 (div running) → mdBusy = 0 before the next edge. An md_D then passes without stall.
- rs_D = rt_D = 0 with a matching rIR_E = 0, regWrite_E = 1, tNew_E = 2 → stall = 0 and all D selects = 0. With HAZARD_STAT_EN, stallCnt is unchanged.

Source files
------------

// File: rtl/hazard_md.sv
// +--------------------------------------------------------------------------+
// | Module  : hazard_md                                                      |
// | Brief   : 5-stage pipeline hazard controller: Tuse/Tnew stalls, D/E/M    |
// |           forward selects and a multiply/divide busy tracker.            |
// |           Optional HAZARD_STAT_EN adds stall statistics counters.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_md #(
    parameter int REG_AW      = 5,
    parameter int T_W         = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [T_W-1:0]    tUseRs,
    input  logic [T_W-1:0]    tUseRt,
    input  logic [T_W-1:0]    tNew_E,
    input  logic [T_W-1:0]    tNew_M,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rt_E,
    input  logic [REG_AW-1:0] rt_M,
    input  logic [REG_AW-1:0] rIR_E,
    input  logic [REG_AW-1:0] rIR_M,
    input  logic [REG_AW-1:0] rIR_W,
    input  logic              regWrite_E,
    input  logic              regWrite_M,
    input  logic              regWrite_W,
    input  logic              md_D,
    input  logic              mdStart_E,
    input  logic              mdDiv_E,
    output logic              stall,
    output logic              flush_E,
    output logic [1:0]        F_mux1_D,
    output logic [1:0]        F_mux2_D,
    output logic [1:0]        F_mux1_E,
    output logic [1:0]        F_mux2_E,
    output logic              F_mux1_M,
    output logic              mdBusy
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]       stallCnt,
    output logic [31:0]       mdStallCnt
`endif
);

    localparam logic [T_W-1:0]   C_TUSE_NONE = {T_W{1'b1}};
    localparam logic [CNT_W-1:0] C_MULT_LD   = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LD    = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_stall_rs, w_stall_rt, w_md_stall;

    function automatic logic src_stall(
        input logic [REG_AW-1:0] src,
        input logic [T_W-1:0]    tuse,
        input logic [REG_AW-1:0] dst_e,
        input logic              we_e,
        input logic [T_W-1:0]    tnew_e,
        input logic [REG_AW-1:0] dst_m,
        input logic              we_m,
        input logic [T_W-1:0]    tnew_m
    );
        logic hit_e, hit_m;
        hit_e = we_e && (src == dst_e) && (tuse < tnew_e);
        hit_m = we_m && (src == dst_m) && (tuse < tnew_m);
        return (src != '0) && (tuse != C_TUSE_NONE) && (hit_e || hit_m);
    endfunction

    // E can only forward once its result exists (tNew_E == 0)
    function automatic logic [1:0] fwd_d(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst_e,
        input logic              we_e,
        input logic [T_W-1:0]    tnew_e,
        input logic [REG_AW-1:0] dst_m,
        input logic              we_m,
        input logic [REG_AW-1:0] dst_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if (we_e && src == dst_e && tnew_e == '0) sel = 2'd3;
            else if (we_m && src == dst_m)            sel = 2'd2;
            else if (we_w && src == dst_w)            sel = 2'd1;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst_m,
        input logic              we_m,
        input logic [REG_AW-1:0] dst_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if (we_m && src == dst_m)      sel = 2'd2;
            else if (we_w && src == dst_w) sel = 2'd1;
        end
        return sel;
    endfunction

    always_comb begin
        w_stall_rs = src_stall(rs_D, tUseRs, rIR_E, regWrite_E, tNew_E,
                               rIR_M, regWrite_M, tNew_M);
        w_stall_rt = src_stall(rt_D, tUseRt, rIR_E, regWrite_E, tNew_E,
                               rIR_M, regWrite_M, tNew_M);
        // Start cycle also stalls so a second md op never enters E behind it
        w_md_stall = md_D && ((cnt_q != '0) || mdStart_E);
        stall      = w_stall_rs || w_stall_rt || w_md_stall;
        flush_E    = stall;
        mdBusy     = (cnt_q != '0);
        F_mux1_D   = fwd_d(rs_D, rIR_E, regWrite_E, tNew_E, rIR_M, regWrite_M,
                           rIR_W, regWrite_W);
        F_mux2_D   = fwd_d(rt_D, rIR_E, regWrite_E, tNew_E, rIR_M, regWrite_M,
                           rIR_W, regWrite_W);
        F_mux1_E   = fwd_e(rs_E, rIR_M, regWrite_M, rIR_W, regWrite_W);
        F_mux2_E   = fwd_e(rt_E, rIR_M, regWrite_M, rIR_W, regWrite_W);
        F_mux1_M   = (rt_M != '0) && regWrite_W && (rt_M == rIR_W);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mdStart_E)          cnt_d = mdDiv_E ? C_DIV_LD : C_MULT_LD;
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] mdStallCnt_q, mdStallCnt_d;

    always_comb begin
        stallCnt_d   = stallCnt_q;
        mdStallCnt_d = mdStallCnt_q;
        if (stall && stallCnt_q != 32'hFFFF_FFFF)
            stallCnt_d = stallCnt_q + 32'd1;
        if (w_md_stall && mdStallCnt_q != 32'hFFFF_FFFF)
            mdStallCnt_d = mdStallCnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q   <= '0;
            mdStallCnt_q <= '0;
        end else begin
            stallCnt_q   <= stallCnt_d;
            mdStallCnt_q <= mdStallCnt_d;
        end
    end

    assign stallCnt   = stallCnt_q;
    assign mdStallCnt = mdStallCnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_md.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_hazard_md                                                   |
// | Brief   : Self-checking bench for hazard_md (directed + random steps).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_md;

    logic       clk, reset;
    logic [1:0] tUseRs, tUseRt, tNew_E, tNew_M;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, rt_M, rIR_E, rIR_M, rIR_W;
    logic       regWrite_E, regWrite_M, regWrite_W, md_D, mdStart_E, mdDiv_E;
    logic       stall, flush_E, F_mux1_M, mdBusy;
    logic [1:0] F_mux1_D, F_mux2_D, F_mux1_E, F_mux2_E;
`ifdef HAZARD_STAT_EN
    logic [31:0] stallCnt, mdStallCnt;
`endif

    int checks   = 0;
    int failures = 0;
    int mcnt     = 0;   // model of MDU cycles remaining
    longint m_sc = 0;   // model stall statistics
    longint m_msc = 0;

    hazard_md dut (
        .clk(clk), .reset(reset), .tUseRs(tUseRs), .tUseRt(tUseRt),
        .tNew_E(tNew_E), .tNew_M(tNew_M), .rs_D(rs_D), .rt_D(rt_D),
        .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M), .rIR_E(rIR_E), .rIR_M(rIR_M),
        .rIR_W(rIR_W), .regWrite_E(regWrite_E), .regWrite_M(regWrite_M),
        .regWrite_W(regWrite_W), .md_D(md_D), .mdStart_E(mdStart_E),
        .mdDiv_E(mdDiv_E), .stall(stall), .flush_E(flush_E),
        .F_mux1_D(F_mux1_D), .F_mux2_D(F_mux2_D), .F_mux1_E(F_mux1_E),
        .F_mux2_E(F_mux2_E), .F_mux1_M(F_mux1_M), .mdBusy(mdBusy)
`ifdef HAZARD_STAT_EN
        , .stallCnt(stallCnt), .mdStallCnt(mdStallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_reg_stall(int src, int tuse);
        if (src == 0 || tuse == 3) return 0;
        if (regWrite_E && src == int'(rIR_E) && tuse < int'(tNew_E)) return 1;
        if (regWrite_M && src == int'(rIR_M) && tuse < int'(tNew_M)) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_d(int src);
        if (src == 0) return 0;
        if (regWrite_E && src == int'(rIR_E) && tNew_E == 0) return 3;
        if (regWrite_M && src == int'(rIR_M)) return 2;
        if (regWrite_W && src == int'(rIR_W)) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(int src);
        if (src == 0) return 0;
        if (regWrite_M && src == int'(rIR_M)) return 2;
        if (regWrite_W && src == int'(rIR_W)) return 1;
        return 0;
    endfunction

    function automatic int m_md_stall();
        return (md_D && (mcnt > 0 || mdStart_E)) ? 1 : 0;
    endfunction

    function automatic int m_stall();
        return (m_reg_stall(rs_D, tUseRs) | m_reg_stall(rt_D, tUseRt) | m_md_stall());
    endfunction

    task automatic check_all();
        check("stall",    32'(stall),    32'(m_stall()));
        check("flush_E",  32'(flush_E),  32'(m_stall()));
        check("mdBusy",   32'(mdBusy),   32'(mcnt > 0));
        check("F_mux1_D", 32'(F_mux1_D), 32'(m_fwd_d(rs_D)));
        check("F_mux2_D", 32'(F_mux2_D), 32'(m_fwd_d(rt_D)));
        check("F_mux1_E", 32'(F_mux1_E), 32'(m_fwd_e(rs_E)));
        check("F_mux2_E", 32'(F_mux2_E), 32'(m_fwd_e(rt_E)));
        check("F_mux1_M", 32'(F_mux1_M), 32'(rt_M != 0 && regWrite_W && rt_M == rIR_W));
`ifdef HAZARD_STAT_EN
        check("stallCnt",   stallCnt,   32'(m_sc));
        check("mdStallCnt", mdStallCnt, 32'(m_msc));
`endif
    endtask

    // Check current cycle, advance one clock, update the model from the applied inputs
    task automatic tick();
        int s, ms;
        #1;
        check_all();
        s  = m_stall();
        ms = m_md_stall();
        @(posedge clk);
        if (reset) begin
            mcnt = 0; m_sc = 0; m_msc = 0;
        end else begin
            if (s != 0  && m_sc  < 64'hFFFF_FFFF) m_sc++;
            if (ms != 0 && m_msc < 64'hFFFF_FFFF) m_msc++;
            if (mdStart_E)     mcnt = mdDiv_E ? 10 : 5;
            else if (mcnt > 0) mcnt = mcnt - 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        tUseRs = 2'd3; tUseRt = 2'd3; tNew_E = 0; tNew_M = 0;
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; rt_M = 0;
        rIR_E = 0; rIR_M = 0; rIR_W = 0;
        regWrite_E = 0; regWrite_M = 0; regWrite_W = 0;
        md_D = 0; mdStart_E = 0; mdDiv_E = 0;
    endtask

    initial begin
        int n, nb;
        reset = 1'b1;
        idle();
        @(negedge clk);
        #1;
        check("reset_mdBusy", 32'(mdBusy), 32'd0);
        check("reset_stall",  32'(stall),  32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Load-use: lw $2 in E, add in D reads $2 at Tuse 1
        rIR_E = 5'd2; regWrite_E = 1; tNew_E = 2'd2; rs_D = 5'd2; tUseRs = 2'd1;
        #1;
        check("lw_stall",   32'(stall),   32'd1);
        check("lw_flush",   32'(flush_E), 32'd1);
        tick();
        idle();
        rIR_M = 5'd2; regWrite_M = 1; tNew_M = 2'd1; rs_D = 5'd2; tUseRs = 2'd1;
        #1;
        check("lw_M_nostall", 32'(stall), 32'd0);
        tick();
        idle();
        rs_E = 5'd2; rIR_M = 5'd2; regWrite_M = 1;
        #1;
        check("lw_fwd_E", 32'(F_mux1_E), 32'd2);
        tick();

        // lui $3 in E forwards straight to D, and wins over M/W
        idle();
        rIR_E = 5'd3; regWrite_E = 1; tNew_E = 0; rs_D = 5'd3; tUseRs = 2'd0;
        #1;
        check("lui_nostall", 32'(stall),    32'd0);
        check("lui_fwd",     32'(F_mux1_D), 32'd3);
        rIR_M = 5'd3; regWrite_M = 1; rIR_W = 5'd3; regWrite_W = 1;
        #1;
        check("lui_prio", 32'(F_mux1_D), 32'd3);
        tick();

        // mult start with mflo in D
        idle();
        n = 0; nb = 0;
        for (int i = 0; i < 20; i++) begin
            md_D = 1; mdStart_E = (i == 0); mdDiv_E = 0;
            #1;
            if (!stall) break;
            n++;
            if (mdBusy) nb++;
            tick();
        end
        check("mult_stall_len", 32'(n),  32'd6);
        check("mult_busy_len",  32'(nb), 32'd5);
        tick();

        // div start followed by non-md work, then mfhi arriving at cnt = 3
        idle();
        mdStart_E = 1; mdDiv_E = 1;
        tick();
        idle();
        nb = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (mdBusy) nb++;
            check("div_nomd_stall", 32'(stall), 32'd0);
            tick();
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            md_D = 1;
            #1;
            if (!stall) break;
            n++;
            tick();
        end
        check("div_prebusy", 32'(nb), 32'd7);
        check("mfhi_stall_len", 32'(n), 32'd3);
        tick();

        // Reset pulsed while a div is running (cnt = 7)
        idle();
        mdStart_E = 1; mdDiv_E = 1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("pre_reset_busy", 32'(mdBusy), 32'd1);
        reset = 1'b1;
        #1;
        mcnt = 0; m_sc = 0; m_msc = 0;
        check("async_reset_busy", 32'(mdBusy), 32'd0);
        reset = 1'b0;
        md_D = 1;
        #1;
        check("post_reset_md", 32'(stall), 32'd0);
        tick();

        // Register 0 never stalls nor forwards
        idle();
        rs_D = 0; rt_D = 0; rIR_E = 0; regWrite_E = 1; tNew_E = 2'd2;
        tUseRs = 0; tUseRt = 0;
        #1;
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_fwd",   32'({F_mux1_D, F_mux2_D}), 32'd0);
`ifdef HAZARD_STAT_EN
        begin
            logic [31:0] before;
            before = stallCnt;
            tick();
            check("r0_stallCnt", stallCnt, before);
        end
`else
        tick();
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            tUseRs = 2'($urandom_range(0, 3)); tUseRt = 2'($urandom_range(0, 3));
            tNew_E = 2'($urandom_range(0, 3)); tNew_M = 2'($urandom_range(0, 3));
            rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
            rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
            rt_M = 5'($urandom_range(0, 3));
            rIR_E = 5'($urandom_range(0, 3)); rIR_M = 5'($urandom_range(0, 3));
            rIR_W = 5'($urandom_range(0, 3));
            regWrite_E = 1'($urandom); regWrite_M = 1'($urandom);
            regWrite_W = 1'($urandom); md_D = 1'($urandom);
            mdStart_E = ($urandom_range(0, 7) == 0); mdDiv_E = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
